// File: rtl/rr_sel4.sv
// rr_sel4: four-channel round-robin selector feeding a single output register stage.
// Optional feature: define RR_SEL4_GRANT_CNT_EN to add an 8-bit saturating grant counter port.
module rr_sel4 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [3:0]   req,
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   output logic [3:0]   gnt,
   output logic [1:0]   s,
   output logic [W-1:0] y,
   output logic         y_valid,
   input  logic         out_ready
`ifdef RR_SEL4_GRANT_CNT_EN
   ,
   output logic [7:0]   grant_cnt
`endif
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t       state;
   state_t       state_next;
   logic [1:0]   last;
   logic [1:0]   sel;
   logic [1:0]   cand;
   logic         found;
   logic         slot_free;
   logic         load;
   logic [W-1:0] sel_data;

   // Round-robin search starting just after the last winner; the last winner itself is tried last.
   always_comb begin
      sel   = last;
      cand  = last;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = last + 2'(k);
         if (!found && req[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

   // Slot/load decision, grant and next state; nothing is granted while reset is held.
   always_comb begin
      state_next = state;
      slot_free  = (state == EMPTY) || out_ready;
      load       = reset_n && slot_free && (req != 4'b0000);
      gnt        = 4'b0000;
      if (load) begin
         gnt        = 4'b0001 << sel;
         state_next = FULL;
      end else if ((state == FULL) && out_ready) begin
         state_next = EMPTY;
      end
   end

   // Data mux for the winning channel.
   always_comb begin
      sel_data = d0;
      case (sel)
         2'd0:    sel_data = d0;
         2'd1:    sel_data = d1;
         2'd2:    sel_data = d2;
         default: sel_data = d3;
      endcase
   end

   // Output register stage; y and s only change on a load, so a drain keeps the old word visible.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
         y     <= '0;
         s     <= 2'b00;
         last  <= 2'd3;
      end else begin
         state <= state_next;
         if (load) begin
            y    <= sel_data;
            s    <= sel;
            last <= sel;
         end
      end
   end

   assign y_valid = (state == FULL);

`ifdef RR_SEL4_GRANT_CNT_EN
   // Count loads, sticking at 255 instead of wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_cnt <= 8'd0;
      end else if (load && (grant_cnt != 8'd255)) begin
         grant_cnt <= grant_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rr_sel4.sv
// tb_rr_sel4: scoreboard bench for rr_sel4; expected words are queued at grant time and popped after the edge.
module tb_rr_sel4;

   localparam int W = 4;

   logic         clk;
   logic         reset_n;
   logic [3:0]   req;
   logic [W-1:0] d0, d1, d2, d3;
   logic [3:0]   gnt;
   logic [1:0]   s;
   logic [W-1:0] y;
   logic         y_valid;
   logic         out_ready;
`ifdef RR_SEL4_GRANT_CNT_EN
   logic [7:0]   grant_cnt;
   int           m_cnt;
`endif

   int compared   = 0;
   int mismatched = 0;

   logic [W+1:0] sb_queue[$];
   logic         m_full;
   logic [1:0]   m_last;
   logic [W-1:0] m_y;
   logic [1:0]   m_s;
   logic [3:0]   seen_gnt;

   rr_sel4 #(.W(W)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .req(req),
      .d0(d0),
      .d1(d1),
      .d2(d2),
      .d3(d3),
      .gnt(gnt),
      .s(s),
      .y(y),
      .y_valid(y_valid),
      .out_ready(out_ready)
`ifdef RR_SEL4_GRANT_CNT_EN
      ,
      .grant_cnt(grant_cnt)
`endif
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_full = 1'b0;
      m_last = 2'd3;
      m_y    = '0;
      m_s    = 2'b00;
      sb_queue.delete();
`ifdef RR_SEL4_GRANT_CNT_EN
      m_cnt = 0;
`endif
   endtask

   // Full reset: checks that reset clears outputs and suppresses grants even with a request pending.
   task automatic doReset();
      @(negedge clk);
      reset_n   = 1'b0;
      req       = 4'b0001;
      out_ready = 1'b1;
      #1;
      modelReset();
      checkOutput("rst_y_valid", y_valid, 0);
      checkOutput("rst_y", y, 0);
      checkOutput("rst_s", s, 0);
      checkOutput("rst_gnt", gnt, 0);
`ifdef RR_SEL4_GRANT_CNT_EN
      checkOutput("rst_cnt", grant_cnt, 0);
`endif
      @(negedge clk);
      req     = 4'b0000;
      reset_n = 1'b1;
   endtask

   // One cycle: drive at negedge, check grant against the model, then check the registered outputs.
   task automatic applyStimulus(input logic [3:0] r, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] e, input logic o);
      logic [W-1:0] dv[4];
      logic [3:0]   exp_gnt;
      logic [1:0]   pick;
      logic         got;
      logic         free;
      logic [W+1:0] ent;
      @(negedge clk);
      req = r; d0 = a; d1 = b; d2 = c; d3 = e; out_ready = o;
      dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = e;
      #1;
      free = !m_full || o;
      got  = 1'b0;
      pick = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         int idx;
         idx = (int'(m_last) + k) % 4;
         if (!got && r[idx]) begin
            got  = 1'b1;
            pick = 2'(idx);
         end
      end
      exp_gnt = (free && got) ? (4'b0001 << pick) : 4'b0000;
      seen_gnt = gnt;
      checkOutput("gnt", gnt, exp_gnt);
      checkOutput("gnt_onehot", ($countones(gnt) <= 1), 1);
      if (free && got) sb_queue.push_back({dv[pick], pick});
      @(posedge clk);
      #1;
      if (free && got) begin
         if (sb_queue.size() == 0) begin
            checkOutput("sb_underflow", 0, 1);
         end else begin
            ent    = sb_queue.pop_front();
            m_y    = ent[W+1:2];
            m_s    = ent[1:0];
            m_full = 1'b1;
            m_last = pick;
         end
`ifdef RR_SEL4_GRANT_CNT_EN
         if (m_cnt < 255) m_cnt++;
`endif
      end else if (m_full && o) begin
         m_full = 1'b0;
      end
      checkOutput("y_valid", y_valid, m_full);
      checkOutput("y", y, m_y);
      checkOutput("s", s, m_s);
`ifdef RR_SEL4_GRANT_CNT_EN
      checkOutput("grant_cnt", grant_cnt, m_cnt);
`endif
   endtask

   logic [1:0]   rot_s[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [W-1:0] rot_y[5] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};

   // Directed scenarios followed by a random phase.
   initial begin
      reset_n = 1'b0; req = '0; d0 = '0; d1 = '0; d2 = '0; d3 = '0; out_ready = 1'b0;
      modelReset();

      // Reset, then first grant favours channel 0.
      doReset();
      applyStimulus(4'b0001, 4'h5, 4'h0, 4'h0, 4'h0, 1'b1);
      checkOutput("first_gnt", seen_gnt, 4'b0001);
      checkOutput("first_y", y, 4'h5);

      // Rotation with all four requesting.
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1111, 4'h0, 4'h4, 4'h8, 4'hC, 1'b1);
         checkOutput("rot_s", s, rot_s[i]);
         checkOutput("rot_y", y, rot_y[i]);
      end

      // Stall: load y=4 from channel 1, then hold with changing data.
      applyStimulus(4'b1111, 4'h1, 4'h4, 4'h9, 4'hD, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b1111, 4'(i + 2), 4'(i + 7), 4'(i + 3), 4'(i + 11), 1'b0);
         checkOutput("stall_gnt", seen_gnt, 4'b0000);
         checkOutput("stall_y", y, 4'h4);
         checkOutput("stall_s", s, 2'b01);
      end
      applyStimulus(4'b1111, 4'h1, 4'h2, 4'h6, 4'h3, 1'b1);
      checkOutput("unstall_gnt", seen_gnt, 4'b0100);

      // Wrap and skip.
      doReset();
      applyStimulus(4'b0100, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
      checkOutput("skip_gnt", seen_gnt, 4'b0100);
      checkOutput("skip_s", s, 2'b10);
      applyStimulus(4'b0011, 4'hA, 4'hB, 4'h3, 4'h4, 1'b1);
      checkOutput("wrap_gnt", seen_gnt, 4'b0001);

      // Drain: word stays on y, valid drops.
      applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      checkOutput("drain_valid", y_valid, 0);
      checkOutput("drain_y", y, 4'hA);
      applyStimulus(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

      // Mid-cycle reset while FULL.
      applyStimulus(4'b1000, 4'h0, 4'h0, 4'h0, 4'h7, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_valid", y_valid, 0);
      checkOutput("midrst_y", y, 0);
      checkOutput("midrst_gnt", gnt, 0);
      modelReset();
      @(negedge clk);
      req = 4'b0000;
      reset_n = 1'b1;
      applyStimulus(4'b1010, 4'h0, 4'h6, 4'h0, 4'h9, 1'b1);
      checkOutput("postrst_gnt", seen_gnt, 4'b0010);

      // Random traffic against the model.
      for (int i = 0; i < 60; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                       4'($urandom), 1'($urandom_range(0, 3) != 0));
      end

`ifdef RR_SEL4_GRANT_CNT_EN
      // Counter saturation.
      doReset();
      for (int i = 0; i < 300; i++) begin
         applyStimulus(4'b0001, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1);
      end
      checkOutput("cnt_sat", grant_cnt, 255);
      doReset();
      checkOutput("cnt_clear", grant_cnt, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rr_sel4.md
RR_SEL4 -- requirements
Module: rr_sel4

Interface
REQ-001 Parameter: W, default 4, data width of each channel and of y.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  4  per-channel request; req[i] means d<i> holds valid data.
REQ-005 Port: d0, d1, d2, d3  input  W each  channel data.
REQ-006 Port: gnt  output  4  one-hot grant; gnt[i]=1 means d<i> is consumed at this clock edge.
REQ-007 Port: s  output  2  registered index of the channel held in y; drives a downstream mux4 select.
REQ-008 Port: y  output  W  registered selected data.
REQ-009 Port: y_valid  output  1  y and s hold valid data.
REQ-010 Port: out_ready  input  1  downstream accepts y this cycle when y_valid=1.

Function
REQ-011 Single output register stage with states EMPTY (y_valid=0) and FULL (y_valid=1).
REQ-012 Slot free: condition (state==EMPTY) or (out_ready==1).
REQ-013 Load: slot free and req!=0, then at the clock edge y<=d[sel], s<=sel, y_valid<=1, last<=sel.
REQ-014 Round-robin pick: sel is the first i with req[i]=1, searching last+1, last+2, last+3, last (mod 4), wrapping 3->0.
REQ-015 gnt is combinational and equals onehot(sel) when a load occurs; gnt=4'b0000 otherwise.
REQ-016 gnt never has more than one bit set, and it is never set while state is FULL and out_ready=0.
REQ-017 Latency: data granted at edge N appears on y with y_valid=1 after edge N (1 cycle).
REQ-018 Transition FULL->EMPTY: out_ready=1 and req=0; y_valid<=0, y and s retain their old value.
REQ-019 FULL with out_ready=1 and req!=0: back-to-back load in the same cycle, state stays FULL, no bubble.
REQ-020 FULL with out_ready=0: y, s, y_valid and last are held stable, gnt=0, req is ignored.
REQ-021 EMPTY with req=0: no state change, and out_ready is ignored.
REQ-022 A single persistent requester is granted on every free cycle, giving full throughput.
REQ-023 With all four requesting and out_ready=1, grants rotate 0,1,2,3,0 in successive cycles.
REQ-024 req or d changes while FULL and stalled have no effect on y.

Reset
REQ-025 When reset_n=0, asynchronously set y_valid=0, y=0, s=2'b00 and last=2'd3, so the first grant favours channel 0.
REQ-026 While reset_n=0, gnt=0.
REQ-027 Reset asserted mid-transfer discards the held word; no grant or output occurs until the first edge after reset_n rises.
REQ-028 Reset deassertion is synchronised externally; the block itself needs no synchroniser.

Configuration
REQ-029 Macro RR_SEL4_GRANT_CNT_EN adds output port grant_cnt (8 bits).
REQ-030 With RR_SEL4_GRANT_CNT_EN defined, grant_cnt increments on every load and saturates at 255.
REQ-031 With RR_SEL4_GRANT_CNT_EN defined, grant_cnt is reset to 0 by reset_n.
REQ-032 Without RR_SEL4_GRANT_CNT_EN, the port and counter are absent and all other behaviour is identical.

Verification
REQ-033 Reset check: reset_n=0 -> y_valid=0, y=0, s=00, gnt=0000; then release with req=0001 and d0=4'h5 -> gnt=0001 in the first cycle, and y=5, s=00, y_valid=1 after the edge.
REQ-034 Rotation check: req=1111, d0..d3=0,4,8,C, out_ready=1 for 5 cycles -> s sequence 00,01,10,11,00, y sequence 0,4,8,C,0, exactly one gnt bit per cycle.
REQ-035 Stall check: FULL with y=4, out_ready=0 for 3 cycles while req=1111 and data changing -> y=4, s=01 stable, gnt=0000; on out_ready=1 -> gnt=0100.
REQ-036 Wrap/skip check: last=3, req=0100 -> gnt=0100, s=10; then req=0011 -> gnt=0001 (wraps past 3 to 0).
REQ-037 Drain and mid-operation reset check: FULL, out_ready=1, req=0 -> y_valid=0 next cycle; FULL, reset_n pulsed low mid-cycle -> y_valid=0 immediately, and the next grant goes to the lowest requester from channel 0.
REQ-038 Counter check (macro defined): 300 consecutive loads -> grant_cnt=255; reset -> grant_cnt=0.
